// File: rtl/scoreboarded_vector_regfile_pkg.sv
// rtl/scoreboarded_vector_regfile_pkg.sv - shared CPU types and machine-flag constants
// Purpose: vector register value, register id and machine flags types, and the
//          HALT flag mask, shared by the register file and its scoreboard.
// Ports:   none (package).
package scoreboarded_vector_regfile_pkg;

    localparam int CPU_NUM_REGS = 32;
    localparam int CPU_LANES    = 4;
    localparam int CPU_LANE_W   = 64;
    localparam int CPU_FLAGS_W  = 64;

    typedef logic [CPU_LANES*CPU_LANE_W-1:0]  VectorValue;
    typedef logic [$clog2(CPU_NUM_REGS)-1:0]  RegisterID;
    typedef logic [CPU_FLAGS_W-1:0]           flags_reg_t;

    // HALT lives in bit 0 of the machine flags word.
    localparam flags_reg_t MACHINE_FLAGS_MASK_HALT = 64'h0000_0000_0000_0001;

endpackage

// File: rtl/regfile_scoreboard_counter.sv
// rtl/regfile_scoreboard_counter.sv - pending-write counter for one architectural register
// Purpose: counts issued-but-not-written results for one register; saturates at
//          all-ones (reported through full) and flags a write that arrives with
//          nothing pending (underflow, one-cycle pulse).
// Ports:   clk, reset (sync, active-high); inc = accepted issue; dec = write to
//          this register; count = current value; full = count at max;
//          underflow = write seen with count 0 and no same-cycle issue.
module regfile_scoreboard_counter
    import scoreboarded_vector_regfile_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d   = count_q;
        underflow = 1'b0;
        // Issue and write in the same cycle cancel out, even at zero.
        if (inc && !dec) begin
            if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                underflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == '1);

endmodule

// File: rtl/scoreboarded_vector_regfile.sv
// rtl/scoreboarded_vector_regfile.sv - vector register file with per-register write scoreboard
// Purpose: NUM_REGS x LANES x LANE_W register file with NUM_RD combinational read
//          ports, a lane-masked write port, a pending-write scoreboard per register,
//          sticky machine flags (HALT blocks issue) and a sticky underflow error.
// Ports:   clk, reset (sync, active-high); rd_addr/rd_data/rd_valid (flattened per
//          port); wr_en/wr_addr/wr_data/wr_lane_mask; inv_en/inv_addr/inv_ready;
//          flag_set_en/flag_set_val/halt_req/flags/halted; sb_err.
// Config:  REGFILE_BYPASS_EN forwards same-cycle write data (and the post-write
//          scoreboard state) to matching read ports.
module scoreboarded_vector_regfile
    import scoreboarded_vector_regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int LANES    = 4,
    parameter int LANE_W   = 64,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 3,
    parameter int FLAGS_W  = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]      rd_addr,
    output logic [NUM_RD*LANES*LANE_W-1:0]          rd_data,
    output logic [NUM_RD-1:0]                       rd_valid,
    input  logic                                    wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]             wr_addr,
    input  logic [LANES*LANE_W-1:0]                 wr_data,
    input  logic [LANES-1:0]                        wr_lane_mask,
    input  logic                                    inv_en,
    input  logic [$clog2(NUM_REGS)-1:0]             inv_addr,
    output logic                                    inv_ready,
    input  logic                                    flag_set_en,
    input  logic [FLAGS_W-1:0]                      flag_set_val,
    input  logic                                    halt_req,
    output logic [FLAGS_W-1:0]                      flags,
    output logic                                    halted,
    output logic                                    sb_err
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int VW = LANES * LANE_W;
    localparam logic [FLAGS_W-1:0] HALT_MASK = FLAGS_W'(MACHINE_FLAGS_MASK_HALT);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [VW-1:0]      regs_q [NUM_REGS];
    logic [VW-1:0]      regs_d [NUM_REGS];
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic               sb_err_q, sb_err_d;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] cnt_full, cnt_uflow, inc_vec, dec_vec;

    logic inv_in_range, wr_in_range, inv_accept, wr_accept;
    logic [AW-1:0] ra;

    assign inv_in_range = (32'(inv_addr) < NUM_REGS);
    assign wr_in_range  = (32'(wr_addr) < NUM_REGS);

    assign halted     = |(flags_q & HALT_MASK);
    assign inv_ready  = inv_in_range && !cnt_full[inv_addr] && !halted;
    assign inv_accept = inv_en && inv_ready;
    // Writes are still accepted while halted so in-flight results can drain.
    assign wr_accept  = wr_en && wr_in_range;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        assign inc_vec[r] = inv_accept && (inv_addr == AW'(r));
        assign dec_vec[r] = wr_accept && (wr_addr == AW'(r));

        regfile_scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_vec[r]),
            .dec       (dec_vec[r]),
            .count     (cnt[r]),
            .full      (cnt_full[r]),
            .underflow (cnt_uflow[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_accept) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_lane_mask[l]) begin
                    regs_d[wr_addr][l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
                end
            end
        end
        flags_d  = flags_q | (flag_set_en ? flag_set_val : '0) | (halt_req ? HALT_MASK : '0);
        sb_err_d = sb_err_q | (|cnt_uflow);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            flags_q  <= '0;
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            flags_q  <= flags_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Read ports; an out-of-range address reads as zero / not valid.
    always_comb begin
        rd_data  = '0;
        rd_valid = '0;
        ra       = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (32'(ra) < NUM_REGS) begin
                rd_data[i*VW +: VW] = regs_q[ra];
                rd_valid[i]         = (cnt[ra] == '0);
                if (BYPASS && wr_accept && (ra == wr_addr)) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (wr_lane_mask[l]) begin
                            rd_data[i*VW + l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
                        end
                    end
                    // Post-write counter: the write retires one unless a same-cycle
                    // accepted issue to this register cancels it.
                    rd_valid[i] = (inc_vec[ra] == 1'b0) && (cnt[ra] <= CNT_W'(1));
                end
            end
        end
    end

    assign flags  = flags_q;
    assign sb_err = sb_err_q;

    always @(posedge clk) begin
        if (!reset) begin
            if (inv_en) assert (inv_in_range);
            if (wr_en)  assert (wr_in_range);
            for (int i = 0; i < NUM_RD; i++) begin
                assert (32'(rd_addr[i*AW +: AW]) < NUM_REGS);
            end
        end
    end

endmodule

// File: tb/tb_scoreboarded_vector_regfile.sv
// tb/tb_scoreboarded_vector_regfile.sv - self-checking bench for scoreboarded_vector_regfile
module tb_scoreboarded_vector_regfile;
    import scoreboarded_vector_regfile_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int LANES    = 4;
    localparam int LANE_W   = 64;
    localparam int NUM_RD   = 2;
    localparam int CNT_W    = 3;
    localparam int FLAGS_W  = 64;
    localparam int AW       = 5;
    localparam int VW       = LANES * LANE_W;
    localparam int MAXP     = 7;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*VW-1:0]   rd_data;
    logic [NUM_RD-1:0]      rd_valid;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [VW-1:0]          wr_data;
    logic [LANES-1:0]       wr_lane_mask;
    logic                   inv_en;
    logic [AW-1:0]          inv_addr;
    logic                   inv_ready;
    logic                   flag_set_en;
    logic [FLAGS_W-1:0]     flag_set_val;
    logic                   halt_req;
    logic [FLAGS_W-1:0]     flags;
    logic                   halted;
    logic                   sb_err;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays of lanes and pending counts.
    logic [LANE_W-1:0]  m_mem [NUM_REGS][LANES];
    int                 m_pend [NUM_REGS];
    logic [FLAGS_W-1:0] m_flags;
    bit                 m_err;

    scoreboarded_vector_regfile #(
        .NUM_REGS(NUM_REGS), .LANES(LANES), .LANE_W(LANE_W),
        .NUM_RD(NUM_RD), .CNT_W(CNT_W), .FLAGS_W(FLAGS_W)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lane_mask(wr_lane_mask),
        .inv_en(inv_en), .inv_addr(inv_addr), .inv_ready(inv_ready),
        .flag_set_en(flag_set_en), .flag_set_val(flag_set_val), .halt_req(halt_req),
        .flags(flags), .halted(halted), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] m_vec(int r);
        logic [VW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*LANE_W +: LANE_W] = m_mem[r][l];
        return v;
    endfunction

    function automatic bit m_ready(int a);
        return (m_pend[a] < MAXP) && ((m_flags & MACHINE_FLAGS_MASK_HALT) == 0);
    endfunction

    task automatic model_step();
        bit acc;
        int ia, wa;
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                m_pend[r] = 0;
                for (int l = 0; l < LANES; l++) m_mem[r][l] = '0;
            end
            m_flags = '0;
            m_err   = 0;
            return;
        end
        ia  = int'(inv_addr);
        wa  = int'(wr_addr);
        acc = inv_en && m_ready(ia);
        if (wr_en) begin
            for (int l = 0; l < LANES; l++)
                if (wr_lane_mask[l]) m_mem[wa][l] = wr_data[l*LANE_W +: LANE_W];
            if (!(acc && ia == wa)) begin
                if (m_pend[wa] > 0) m_pend[wa]--;
                else m_err = 1;
            end
        end
        if (acc && !(wr_en && ia == wa)) m_pend[ia]++;
        if (flag_set_en) m_flags |= flag_set_val;
        if (halt_req) m_flags |= MACHINE_FLAGS_MASK_HALT;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; wr_en = 0; inv_en = 0; flag_set_en = 0; halt_req = 0;
        wr_lane_mask = '0; flag_set_val = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; inv_en = 1; inv_addr = 5'd1; wr_en = 1; wr_addr = 5'd1;
        wr_data = {VW{1'b1}}; wr_lane_mask = '1; flag_set_en = 1; flag_set_val = '1; halt_req = 1;
        tick();
        idle();
        set_rd(1, 31);
        checks++; if (rd_valid !== 2'b11) begin errors++; $display("FAIL reset_rd_valid got %b want 11", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        checks++; if (inv_ready !== 1'b1) begin errors++; $display("FAIL reset_inv_ready got %b want 1", inv_ready); end
        checks++; if (halted !== 1'b0 || flags !== '0) begin errors++; $display("FAIL reset_flags got %h/%b want 0/0", flags, halted); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %b want 0", sb_err); end
    endtask

    task automatic test_issue_write();
        idle();
        inv_en = 1; inv_addr = 5'd5;
        set_rd(5, 0);
        checks++; if (inv_ready !== 1'b1) begin errors++; $display("FAIL iw_ready got %b want 1", inv_ready); end
        tick();
        idle();
        set_rd(5, 0);
        checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL iw_pending got %b want 0", rd_valid[0]); end
        wr_en = 1; wr_addr = 5'd5; wr_data = {LANES{64'hAA}}; wr_lane_mask = '1;
        tick();
        idle();
        set_rd(5, 0);
        checks++; if (rd_valid[0] !== 1'b1) begin errors++; $display("FAIL iw_valid got %b want 1", rd_valid[0]); end
        checks++; if (rd_data[0 +: VW] !== {LANES{64'hAA}}) begin errors++; $display("FAIL iw_data got %h want %h", rd_data[0 +: VW], {LANES{64'hAA}}); end
    endtask

    task automatic test_saturation();
        idle();
        inv_addr = 5'd3;
        for (int k = 0; k < MAXP; k++) begin
            inv_en = 1;
            #1;
            checks++; if (inv_ready !== 1'b1) begin errors++; $display("FAIL sat_issue%0d got %b want 1", k, inv_ready); end
            tick();
        end
        inv_en = 1;
        #1;
        checks++; if (inv_ready !== 1'b0) begin errors++; $display("FAIL sat_full got %b want 0", inv_ready); end
        tick();
        idle();
        wr_addr = 5'd3; wr_lane_mask = '1; wr_data = '0;
        for (int k = 0; k < MAXP; k++) begin
            set_rd(3, 3);
            checks++; if (rd_valid[1] !== 1'b0) begin errors++; $display("FAIL sat_drain%0d got %b want 0", k, rd_valid[1]); end
            wr_en = 1;
            tick();
        end
        idle();
        set_rd(3, 3);
        checks++; if (rd_valid[1] !== 1'b1) begin errors++; $display("FAIL sat_empty got %b want 1", rd_valid[1]); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sat_sb_err got %b want 0", sb_err); end
    endtask

    task automatic test_same_cycle();
        logic [VW-1:0] d;
        idle();
        inv_en = 1; inv_addr = 5'd2;
        tick();
        d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        inv_en = 1; inv_addr = 5'd2; wr_en = 1; wr_addr = 5'd2; wr_data = d; wr_lane_mask = '1;
        tick();
        idle();
        set_rd(0, 2);
        checks++; if (rd_valid[1] !== 1'b0) begin errors++; $display("FAIL same_pending got %b want 0", rd_valid[1]); end
        checks++; if (rd_data[VW +: VW] !== d) begin errors++; $display("FAIL same_data got %h want %h", rd_data[VW +: VW], d); end
        wr_en = 1; wr_addr = 5'd2; wr_lane_mask = '1; wr_data = d;
        tick();
        idle();
        set_rd(0, 2);
        checks++; if (rd_valid[1] !== 1'b1 || sb_err !== 1'b0) begin errors++; $display("FAIL same_retire got %b/%b want 1/0", rd_valid[1], sb_err); end
    endtask

    task automatic test_underflow();
        idle();
        wr_en = 1; wr_addr = 5'd9; wr_data = '1; wr_lane_mask = '1;
        tick();
        idle();
        set_rd(9, 9);
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL uflow_set got %b want 1", sb_err); end
        checks++; if (rd_valid !== 2'b11 || rd_data[0 +: VW] !== {VW{1'b1}}) begin errors++; $display("FAIL uflow_write got %b %h want 11 all-ones", rd_valid, rd_data[0 +: VW]); end
        for (int k = 0; k < 3; k++) tick();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL uflow_sticky got %b want 1", sb_err); end
    endtask

    task automatic test_lane_mask();
        idle();
        wr_en = 1; wr_addr = 5'd7; wr_data = {LANES{64'h1111_1111_1111_1111}}; wr_lane_mask = 4'b1111;
        tick();
        wr_data = {LANES{64'hFFFF_FFFF_FFFF_FFFF}}; wr_lane_mask = 4'b0101;
        tick();
        idle();
        set_rd(7, 0);
        checks++; if (rd_data[0 +: 64] !== 64'hFFFF_FFFF_FFFF_FFFF || rd_data[128 +: 64] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL mask_written got %h %h want all-F", rd_data[0 +: 64], rd_data[128 +: 64]); end
        checks++; if (rd_data[64 +: 64] !== 64'h1111_1111_1111_1111 || rd_data[192 +: 64] !== 64'h1111_1111_1111_1111) begin
            errors++; $display("FAIL mask_held got %h %h want all-1", rd_data[64 +: 64], rd_data[192 +: 64]); end
    endtask

    task automatic test_random();
        int a0, a1;
        for (int c = 0; c < 400; c++) begin
            idle();
            inv_en       = ($urandom_range(0, 9) < 6);
            inv_addr     = AW'($urandom_range(0, 5));
            wr_en        = ($urandom_range(0, 9) < 5);
            wr_addr      = AW'($urandom_range(0, 5));
            wr_data      = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            wr_lane_mask = LANES'($urandom());
            flag_set_en  = ($urandom_range(0, 19) == 0);
            flag_set_val = {$urandom(), $urandom()} & ~MACHINE_FLAGS_MASK_HALT;
            a0 = $urandom_range(0, 6);
            a1 = $urandom_range(0, 6);
            set_rd(a0, a1);
            checks++; if (inv_ready !== m_ready(int'(inv_addr))) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, inv_ready, m_ready(int'(inv_addr))); end
            checks++; if (rd_valid[0] !== (m_pend[a0] == 0) || rd_valid[1] !== (m_pend[a1] == 0)) begin
                errors++; $display("FAIL rnd_valid c%0d got %b want %b%b", c, rd_valid, m_pend[a1] == 0, m_pend[a0] == 0); end
            checks++; if (rd_data[0 +: VW] !== m_vec(a0) || rd_data[VW +: VW] !== m_vec(a1)) begin
                errors++; $display("FAIL rnd_data c%0d r%0d got %h want %h", c, a0, rd_data[0 +: VW], m_vec(a0)); end
            checks++; if (flags !== m_flags || sb_err !== m_err) begin errors++; $display("FAIL rnd_flags c%0d got %h/%b want %h/%b", c, flags, sb_err, m_flags, m_err); end
            tick();
        end
    endtask

    task automatic test_halt_reset();
        logic [VW-1:0] d;
        idle();
        halt_req = 1;
        tick();
        idle();
        inv_en = 1; inv_addr = 5'd4;
        #1;
        checks++; if (halted !== 1'b1 || inv_ready !== 1'b0) begin errors++; $display("FAIL halt_block got %b/%b want 1/0", halted, inv_ready); end
        tick();
        idle();
        d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        wr_en = 1; wr_addr = 5'd4; wr_data = d; wr_lane_mask = '1;
        tick();
        idle();
        set_rd(4, 4);
        checks++; if (rd_data[0 +: VW] !== d || rd_valid[0] !== (m_pend[4] == 0)) begin errors++; $display("FAIL halt_drain got %h want %h", rd_data[0 +: VW], d); end
        reset = 1;
        tick();
        idle();
        #1;
        checks++; if (flags !== '0 || halted !== 1'b0 || sb_err !== 1'b0 || inv_ready !== 1'b1) begin
            errors++; $display("FAIL halt_reset got %h/%b/%b/%b want 0/0/0/1", flags, halted, sb_err, inv_ready); end
        for (int r = 0; r < NUM_REGS; r += 2) begin
            set_rd(r, r + 1);
            checks++; if (rd_valid !== 2'b11 || rd_data !== '0) begin errors++; $display("FAIL halt_reset_r%0d got %b %h want 11 0", r, rd_valid, rd_data); end
        end
    endtask

    initial begin
        idle();
        rd_addr = '0; wr_addr = '0; inv_addr = '0; wr_data = '0;
        reset = 1;
        test_reset();
        test_issue_write();
        test_saturation();
        test_same_cycle();
        test_underflow();
        test_lane_mask();
        test_random();
        test_halt_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
